// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared constants and types for the ALU control sequencer
package alu_ctrl_pkg;

  localparam int CTR_W          = 4;
  localparam int DEF_MUL_CYCLES = 4;
  localparam int DEF_DIV_CYCLES = 8;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_MUL     = 4'b1000;
  localparam logic [3:0] ALU_DIV     = 4'b1001;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;

  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_SUB = 6'b000001;
  localparam logic [5:0] FN_AND = 6'b000010;
  localparam logic [5:0] FN_OR  = 6'b000011;
  localparam logic [5:0] FN_SLT = 6'b000100;
  localparam logic [5:0] FN_NOR = 6'b000101;
  localparam logic [5:0] FN_MUL = 6'b000110;
  localparam logic [5:0] FN_DIV = 6'b000111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    BUSY = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational {alu_op, funct} to ALU control code decoder
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6,
  parameter int CNT_W   = 4
) (
  input  logic [ALUOP_W-1:0] aluOp,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CNT_W-1:0]   code,
  output logic               multi,
  output logic               isDiv,
  output logic               illegal
);

  always_comb begin
    code    = ALU_ILLEGAL;
    multi   = 1'b0;
    isDiv   = 1'b0;
    illegal = 1'b0;
    case (aluOp)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: code = ALU_ADD;
          FN_SUB: code = ALU_SUB;
          FN_AND: code = ALU_AND;
          FN_OR:  code = ALU_OR;
          FN_SLT: code = ALU_SLT;
          FN_NOR: code = ALU_NOR;
          FN_MUL: begin
            code  = ALU_MUL;
            multi = 1'b1;
          end
          FN_DIV: begin
            code  = ALU_DIV;
            multi = 1'b1;
            isDiv = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_SLT:  code = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered, handshaked ALU control with multi-cycle MUL/DIV sequencing
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 3,
  parameter int FUNCT_W    = 6,
  parameter int CNT_W      = 4,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   alu_cnt,
  output logic               err,
  output logic               busy
);

  localparam logic [CTR_W-1:0] MUL_LOAD = CTR_W'(MUL_CYCLES - 1);
  localparam logic [CTR_W-1:0] DIV_LOAD = CTR_W'(DIV_CYCLES - 1);

  state_t             state, stateNext;
  logic [CTR_W-1:0]   cnt, cntNext;
  logic [CNT_W-1:0]   codeReg;
  logic               errReg;
  logic [CNT_W-1:0]   decCode;
  logic               decMulti, decIsDiv, decIllegal;
  logic               accept;

  alu_ctrl_decode #(
    .ALUOP_W(ALUOP_W),
    .FUNCT_W(FUNCT_W),
    .CNT_W  (CNT_W)
  ) uDecode (
    .aluOp  (alu_op),
    .funct  (funct),
    .code   (decCode),
    .multi  (decMulti),
    .isDiv  (decIsDiv),
    .illegal(decIllegal)
  );

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      codeReg <= '0;
      errReg  <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept) begin
        codeReg <= decCode;
        errReg  <= decIllegal;
      end else if (flush) begin
        codeReg <= '0;
        errReg  <= 1'b0;
      end
    end
  end

  // BUSY leaves on the edge where the counter steps 1 -> 0, so output lands CYCLES clocks after accept.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: if (accept) stateNext = decMulti ? BUSY : HOLD;
      HOLD: if (out_ready) stateNext = accept ? (decMulti ? BUSY : HOLD) : IDLE;
      BUSY: if (cnt <= CTR_W'(1)) stateNext = HOLD;
      default: stateNext = IDLE;
    endcase
    if (accept && decMulti)
      cntNext = decIsDiv ? DIV_LOAD : MUL_LOAD;
    else if (state == BUSY && cnt != '0)
      cntNext = cnt - CTR_W'(1);
    if (flush) begin
      stateNext = IDLE;
      cntNext   = '0;
    end
  end

  always_comb begin
    out_valid = (state == HOLD);
    busy      = (state == BUSY);
    in_ready  = !rst && !flush && (state != BUSY) && (!out_valid || out_ready);
    alu_cnt   = codeReg;
    err       = errReg;
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - self-checking bench for alu_ctrl_seq
module tb_alu_ctrl_seq;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_cnt;
  logic       err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] expCode;
  logic       expErr;
  logic [4:0] sbQueue[$];

  typedef struct {
    logic [2:0] op;
    logic [5:0] fn;
    logic [3:0] code;
    logic       err;
  } vec_t;

  vec_t vecs[14];

  alu_ctrl_seq dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .funct    (funct),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_cnt  (alu_cnt),
    .err      (err),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [5:0] fn, input logic [3:0] code, input logic e);
    in_valid = 1'b1;
    alu_op   = op;
    funct    = fn;
    expCode  = code;
    expErr   = e;
  endtask

  // Samples at the falling edge: retires a transfer, then records a new accept.
  task automatic sample();
    logic [4:0] ent;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sbQueue.size() == 0) begin
        check("sb_unexpected_output", 32'd1, 32'd0);
      end else begin
        ent = sbQueue.pop_front();
        check("sb_alu_cnt", {28'd0, alu_cnt}, {28'd0, ent[4:1]});
        check("sb_err", {31'd0, err}, {31'd0, ent[0]});
      end
    end
    if (rst || flush) sbQueue.delete();
    else if (in_valid && in_ready) sbQueue.push_back({expCode, expErr});
  endtask

  initial begin
    int quietViolations;
    vecs[0]  = '{3'b000, 6'b000000, 4'b0010, 1'b0};
    vecs[1]  = '{3'b000, 6'b000001, 4'b0110, 1'b0};
    vecs[2]  = '{3'b000, 6'b000010, 4'b0000, 1'b0};
    vecs[3]  = '{3'b000, 6'b000011, 4'b0001, 1'b0};
    vecs[4]  = '{3'b000, 6'b000100, 4'b0111, 1'b0};
    vecs[5]  = '{3'b000, 6'b000101, 4'b1100, 1'b0};
    vecs[6]  = '{3'b001, 6'b101010, 4'b0010, 1'b0};
    vecs[7]  = '{3'b010, 6'b000000, 4'b0110, 1'b0};
    vecs[8]  = '{3'b011, 6'b111111, 4'b0000, 1'b0};
    vecs[9]  = '{3'b100, 6'b000000, 4'b0001, 1'b0};
    vecs[10] = '{3'b101, 6'b000000, 4'b0111, 1'b0};
    vecs[11] = '{3'b111, 6'b000000, 4'b1111, 1'b1};
    vecs[12] = '{3'b000, 6'b111111, 4'b1111, 1'b1};
    vecs[13] = '{3'b110, 6'b000110, 4'b1111, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; funct = '0; expCode = '0; expErr = 1'b0;
    nextCycle();
    sample();
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_alu_cnt", {28'd0, alu_cnt}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    nextCycle();
    rst = 1'b0;
    sample();
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back single-cycle ops: one accept and one result per clock.
    for (int i = 0; i < 14; i++) begin
      nextCycle();
      drive(vecs[i].op, vecs[i].fn, vecs[i].code, vecs[i].err);
      sample();
      check($sformatf("stream_in_ready_%0d", i), {31'd0, in_ready}, 32'd1);
      if (i > 0) check($sformatf("stream_out_valid_%0d", i), {31'd0, out_valid}, 32'd1);
    end
    nextCycle();
    in_valid = 1'b0;
    sample();
    check("stream_last_out_valid", {31'd0, out_valid}, 32'd1);
    nextCycle();
    sample();
    check("stream_drained_out_valid", {31'd0, out_valid}, 32'd0);

    // MUL: busy for three clocks, result on the fourth.
    nextCycle();
    drive(3'b000, 6'b000110, 4'b1000, 1'b0);
    sample();
    check("mul_accept", {31'd0, in_ready}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      nextCycle();
      in_valid = 1'b0;
      sample();
      check($sformatf("mul_busy_%0d", k), {31'd0, busy}, 32'd1);
      check($sformatf("mul_in_ready_%0d", k), {31'd0, in_ready}, 32'd0);
      check($sformatf("mul_out_valid_%0d", k), {31'd0, out_valid}, 32'd0);
      check($sformatf("mul_code_busy_%0d", k), {28'd0, alu_cnt}, 32'h8);
    end
    nextCycle();
    sample();
    check("mul_done_out_valid", {31'd0, out_valid}, 32'd1);
    check("mul_done_busy", {31'd0, busy}, 32'd0);

    // DIV: busy for seven clocks, result on the eighth.
    nextCycle();
    drive(3'b000, 6'b000111, 4'b1001, 1'b0);
    sample();
    check("div_accept", {31'd0, in_ready}, 32'd1);
    for (int k = 1; k <= 7; k++) begin
      nextCycle();
      in_valid = 1'b0;
      sample();
      check($sformatf("div_busy_%0d", k), {31'd0, busy & ~out_valid}, 32'd1);
    end
    nextCycle();
    sample();
    check("div_done_out_valid", {31'd0, out_valid}, 32'd1);
    check("div_done_busy", {31'd0, busy}, 32'd0);

    // Back-pressure: SUB held while out_ready is low, next op accepted when it rises.
    nextCycle();
    out_ready = 1'b0;
    drive(3'b010, 6'b000000, 4'b0110, 1'b0);
    sample();
    check("bp_accept", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      drive(3'b001, 6'b000000, 4'b0010, 1'b0);
      sample();
      check($sformatf("bp_hold_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_hold_code_%0d", k), {28'd0, alu_cnt}, 32'h6);
      check($sformatf("bp_hold_in_ready_%0d", k), {31'd0, in_ready}, 32'd0);
    end
    nextCycle();
    out_ready = 1'b1;
    sample();
    check("bp_resume_in_ready", {31'd0, in_ready}, 32'd1);
    nextCycle();
    in_valid = 1'b0;
    sample();
    check("bp_next_code", {28'd0, alu_cnt}, 32'h2);

    // Flush two clocks into a DIV: op dropped, an input offered during flush is ignored.
    nextCycle();
    drive(3'b000, 6'b000111, 4'b1001, 1'b0);
    sample();
    nextCycle();
    in_valid = 1'b0;
    sample();
    nextCycle();
    flush = 1'b1;
    drive(3'b001, 6'b000000, 4'b0010, 1'b0);
    sample();
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    nextCycle();
    flush = 1'b0;
    in_valid = 1'b0;
    sample();
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
    quietViolations = 0;
    for (int k = 0; k < 10; k++) begin
      nextCycle();
      sample();
      if (out_valid || busy) quietViolations++;
    end
    check("flush_no_stale_output", quietViolations, 32'd0);

    // Flush coinciding with a transfer: the result still counts.
    nextCycle();
    drive(3'b011, 6'b000000, 4'b0000, 1'b0);
    sample();
    nextCycle();
    in_valid = 1'b0;
    flush = 1'b1;
    sample();
    check("flush_xfer_valid", {31'd0, out_valid}, 32'd1);
    nextCycle();
    flush = 1'b0;
    sample();
    check("flush_xfer_cleared", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a MUL.
    nextCycle();
    drive(3'b000, 6'b000110, 4'b1000, 1'b0);
    sample();
    nextCycle();
    in_valid = 1'b0;
    sample();
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    nextCycle();
    rst = 1'b1;
    drive(3'b001, 6'b000000, 4'b0010, 1'b0);
    sample();
    check("rst_in_ready_first", {31'd0, in_ready}, 32'd0);
    nextCycle();
    sample();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_alu_cnt", {28'd0, alu_cnt}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    nextCycle();
    rst = 1'b0;
    in_valid = 1'b0;
    sample();
    check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
    quietViolations = 0;
    for (int k = 0; k < 6; k++) begin
      nextCycle();
      sample();
      if (out_valid) quietViolations++;
    end
    check("rst_no_output", quietViolations, 32'd0);

    check("sb_drained", sbQueue.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
